direction_angle_resolver: RTL

- Converts a packed Cartesian direction vector {x, y} into polar form: a phase angle in 2Q13 radians and an unscaled magnitude.
- Uses a sequential CORDIC in vectoring mode.
- Sits downstream of the per-frequency direction computation: it turns the summed x/y phase-difference vector back into a bearing for the localization output and display logic.
- Uses a valid/ready handshake on both sides and processes one vector at a time.

---
 rtl/localization_pkg.sv | 33 +++
 rtl/cordic_atan_lut.sv | 33 +++
 rtl/direction_angle_resolver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/localization_pkg.sv
// localization_pkg
//   Shared constants and types for the localization datapath.
//   Angles are 2Q13 fixed point (pi = 25736). The state type is used by
//   direction_angle_resolver; wrap_angle folds a CORDIC z accumulator
//   back into the half-open interval (-pi, pi].
package localization_pkg;

  localparam logic [15:0] PI_2Q13      = 16'h6488;   // 25736
  localparam logic [16:0] TWO_PI_2Q13  = 17'hC910;   // 51472
  localparam logic [15:0] HALF_PI_2Q13 = 16'd12868;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } resolver_state_t;

  // Map an 18-bit signed angle into (-pi, pi]; +pi stays, -pi becomes +pi.
  function automatic logic signed [17:0] wrap_angle(input logic signed [17:0] z);
    logic signed [17:0] pi_s;
    logic signed [17:0] two_pi_s;
    pi_s     = signed'({2'b00, PI_2Q13});
    two_pi_s = signed'({1'b0, TWO_PI_2Q13});
    if (z > pi_s) begin
      wrap_angle = z - two_pi_s;
    end else if (z <= -pi_s) begin
      wrap_angle = z + two_pi_s;
    end else begin
      wrap_angle = z;
    end
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut
//   Combinational arctangent table for CORDIC micro-rotations.
//   Ports:
//     index  in  4   micro-rotation number i
//     atan   out 16  atan(2^-i) in 2Q13 radians; 0 for i > 13
module cordic_atan_lut (
  input  logic [3:0]  index,
  output logic [15:0] atan
);

  // Table lookup; entries past i=13 round to zero in 2Q13.
  always_comb begin
    atan = 16'd0;
    case (index)
      4'd0:    atan = 16'd6434;
      4'd1:    atan = 16'd3798;
      4'd2:    atan = 16'd2007;
      4'd3:    atan = 16'd1019;
      4'd4:    atan = 16'd511;
      4'd5:    atan = 16'd256;
      4'd6:    atan = 16'd128;
      4'd7:    atan = 16'd64;
      4'd8:    atan = 16'd32;
      4'd9:    atan = 16'd16;
      4'd10:   atan = 16'd8;
      4'd11:   atan = 16'd4;
      4'd12:   atan = 16'd2;
      4'd13:   atan = 16'd1;
      default: atan = 16'd0;
    endcase
  end

endmodule

// File: rtl/direction_angle_resolver.sv
// direction_angle_resolver
//   Sequential vectoring-mode CORDIC: converts a packed {x, y} direction
//   vector into a 2Q13 angle in (-pi, pi] and an uncompensated magnitude
//   (|v| * K, K ~= 1.64676). One vector in flight at a time.
//   Ports:
//     clk_in         in   1               clock
//     rst_in         in   1               synchronous active-high reset
//     vector_in      in   DATA_WIDTH      {x, y}, each signed DATA_WIDTH/2
//     valid_in       in   1               vector_in valid
//     ready_out      out  1               block can accept a vector
//     angle_out      out  16              signed 2Q13 angle
//     magnitude_out  out  DATA_WIDTH/2+1  unsigned magnitude * K
//     valid_out      out  1               angle_out/magnitude_out valid
//     ready_in       in   1               downstream accepts the result
module direction_angle_resolver
  import localization_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITERATIONS = 14
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [DATA_WIDTH-1:0]   vector_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [15:0]             angle_out,
  output logic [DATA_WIDTH/2:0]   magnitude_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  localparam int HW = DATA_WIDTH / 2;
  // Three guard bits: one for negating -2^(HW-1), two for CORDIC growth.
  localparam int IW = HW + 3;

  resolver_state_t state_r;
  resolver_state_t state_next_s;

  logic signed [IW-1:0] x_r;
  logic signed [IW-1:0] y_r;
  logic signed [17:0]   z_r;
  logic [3:0]           iter_r;

  logic [15:0]          angle_r;
  logic [HW:0]          magnitude_r;
  logic                 valid_r;
  logic                 ready_r;

  logic signed [HW-1:0] x_in_s;
  logic signed [HW-1:0] y_in_s;
  logic signed [IW-1:0] x_ext_s;
  logic signed [IW-1:0] y_ext_s;
  logic                 accept_s;
  logic                 is_zero_s;
  logic                 last_iter_s;

  logic signed [IW-1:0] fold_x_s;
  logic signed [IW-1:0] fold_y_s;
  logic signed [17:0]   fold_z_s;

  logic [15:0]          atan_s;
  logic signed [17:0]   atan_ext_s;
  logic signed [IW-1:0] x_sh_s;
  logic signed [IW-1:0] y_sh_s;
  logic signed [IW-1:0] x_rot_s;
  logic signed [IW-1:0] y_rot_s;
  logic signed [17:0]   z_rot_s;

  assign x_in_s      = signed'(vector_in[DATA_WIDTH-1:HW]);
  assign y_in_s      = signed'(vector_in[HW-1:0]);
  assign x_ext_s     = {{3{x_in_s[HW-1]}}, x_in_s};
  assign y_ext_s     = {{3{y_in_s[HW-1]}}, y_in_s};
  assign accept_s    = valid_in && ready_r && (state_r == IDLE);
  assign is_zero_s   = (x_in_s == '0) && (y_in_s == '0);
  assign last_iter_s = (iter_r == 4'(ITERATIONS - 1));

  cordic_atan_lut u_atan_lut (
    .index (iter_r),
    .atan  (atan_s)
  );

  assign atan_ext_s = signed'({2'b00, atan_s});

  // Quadrant fold: rotate left-half-plane inputs by -/+90 degrees so the
  // CORDIC only has to cover (-pi/2, pi/2).
  always_comb begin
    fold_x_s = x_ext_s;
    fold_y_s = y_ext_s;
    fold_z_s = 18'sd0;
    if (!x_in_s[HW-1]) begin
      fold_x_s = x_ext_s;
      fold_y_s = y_ext_s;
      fold_z_s = 18'sd0;
    end else if (!y_in_s[HW-1]) begin
      fold_x_s = y_ext_s;
      fold_y_s = -x_ext_s;
      fold_z_s = signed'({2'b00, HALF_PI_2Q13});
    end else begin
      fold_x_s = -y_ext_s;
      fold_y_s = x_ext_s;
      fold_z_s = -signed'({2'b00, HALF_PI_2Q13});
    end
  end

  // One micro-rotation driving y toward zero, from pre-update x/y/z values.
  always_comb begin
    x_sh_s  = x_r >>> iter_r;
    y_sh_s  = y_r >>> iter_r;
    x_rot_s = x_r;
    y_rot_s = y_r;
    z_rot_s = z_r;
    if (!y_r[IW-1]) begin
      x_rot_s = x_r + y_sh_s;
      y_rot_s = y_r - x_sh_s;
      z_rot_s = z_r + atan_ext_s;
    end else begin
      x_rot_s = x_r - y_sh_s;
      y_rot_s = y_r + x_sh_s;
      z_rot_s = z_r - atan_ext_s;
    end
  end

  // Next-state logic; the zero vector has no defined angle and skips ROTATE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = is_zero_s ? DONE : ROTATE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROTATE: begin
        if (last_iter_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ROTATE;
        end
      end
      DONE: begin
        if (valid_r && ready_in) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs. DONE spends its first cycle capturing
  // the wrapped angle, then holds everything until the downstream handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= 18'sd0;
      iter_r      <= 4'd0;
      angle_r     <= 16'd0;
      magnitude_r <= '0;
      valid_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      ready_r <= (state_next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r    <= fold_x_s;
            y_r    <= fold_y_s;
            z_r    <= fold_z_s;
            iter_r <= 4'd0;
          end
        end
        ROTATE: begin
          x_r    <= x_rot_s;
          y_r    <= y_rot_s;
          z_r    <= z_rot_s;
          iter_r <= iter_r + 4'd1;
        end
        DONE: begin
          if (!valid_r) begin
            angle_r     <= 16'(wrap_angle(z_r));
            magnitude_r <= x_r[HW:0];
            valid_r     <= 1'b1;
          end else if (ready_in) begin
            valid_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out     = ready_r;
  assign angle_out     = angle_r;
  assign magnitude_out = magnitude_r;
  assign valid_out     = valid_r;

endmodule
